// File: rtl/encoder_pkg.sv
// Shared types and constants for the rotary-encoder front end.
// Phase names, direction codes and Gray-code move classification.
package encoder_pkg;

  localparam int DEF_FILTER_WIDTH = 11;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_10 = 2'b10,
    PH_11 = 2'b11
  } phase_t;

  typedef enum logic [1:0] {
    MV_HOLD,
    MV_CW,
    MV_CCW,
    MV_BAD
  } move_t;

  // Position of a phase along the CW cycle 11 -> 10 -> 00 -> 01.
  function automatic logic [1:0] gray_pos(input logic [1:0] p);
    case (p)
      PH_11:   gray_pos = 2'd0;
      PH_10:   gray_pos = 2'd1;
      PH_00:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  // Distance two along the cycle means both pins moved at once.
  function automatic move_t classify(
    input logic [1:0] from,
    input logic [1:0] to
  );
    logic [1:0] d;
    d = gray_pos(to) - gray_pos(from);
    case (d)
      2'd0:    classify = MV_HOLD;
      2'd1:    classify = MV_CW;
      2'd3:    classify = MV_CCW;
      default: classify = MV_BAD;
    endcase
  endfunction

endpackage

// File: rtl/quadrature_step_filter_if.sv
// Pin/result bundle of the quadrature step filter.
// slave: a, b, err_clr in; step, dir, err, phase out. master: mirror.
interface quadrature_step_filter_if;
  logic       a;
  logic       b;
  logic       err_clr;
  logic       step;
  logic       dir;
  logic       err;
  logic [1:0] phase;

  modport master (
    output a, b, err_clr,
    input  step, dir, err, phase
  );

  modport slave (
    input  a, b, err_clr,
    output step, dir, err, phase
  );
endinterface

// File: rtl/input_filter.sv
// One encoder channel: synchroniser chain followed by debounce counter.
// Ports: clk, rst_n, raw (async pin) in; filt (clean level) out.
module input_filter #(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_WIDTH = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  logic [SYNC_STAGES-1:0]  sync_q;
  logic [FILTER_WIDTH-1:0] cnt;
  logic                    synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Any return to the filtered level wipes the count, so short
  // bounces never accumulate toward a toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      filt   <= 1'b1;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      if (synced == filt) begin
        cnt <= '0;
      end else if (&cnt) begin
        filt <= ~filt;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quadrature_step_filter.sv
// Encoder front end: filtered A/B to detent step pulses, dir and err.
// Ports: clk, rst_n; bus (slave): a, b, err_clr in; step, dir, err, phase out.
module quadrature_step_filter
  import encoder_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_WIDTH   = DEF_FILTER_WIDTH,
  parameter int EDGES_PER_STEP = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  quadrature_step_filter_if.slave  bus
);

  localparam logic signed [2:0] ACC_MAX = 3'(EDGES_PER_STEP - 1);
  localparam logic signed [2:0] ACC_MIN = -ACC_MAX;

  logic              fa;
  logic              fb;
  logic [1:0]        pair;
  move_t             mv;
  phase_t            phase_q;
  logic signed [2:0] acc;
  logic              step_q;
  logic              dir_q;
  logic              err_q;

  input_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_WIDTH (FILTER_WIDTH)
  ) u_fa (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.a),
    .filt  (fa)
  );

  input_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_WIDTH (FILTER_WIDTH)
  ) u_fb (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.b),
    .filt  (fb)
  );

  assign pair = {fa, fb};

  always_comb begin
    mv = classify(phase_q, pair);
  end

  // phase always follows the filtered pair, so after an illegal
  // jump the tracker restarts from wherever the pins now sit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_11;
      acc     <= '0;
      step_q  <= 1'b0;
      dir_q   <= DIR_CCW;
      err_q   <= 1'b0;
    end else begin
      phase_q <= phase_t'(pair);
      step_q  <= 1'b0;
      unique case (mv)
        MV_HOLD: ;
        MV_CW: begin
          if (acc == ACC_MAX) begin
            step_q <= 1'b1;
            dir_q  <= DIR_CW;
            acc    <= '0;
          end else begin
            acc <= acc + 3'sd1;
          end
        end
        MV_CCW: begin
          if (acc == ACC_MIN) begin
            step_q <= 1'b1;
            dir_q  <= DIR_CCW;
            acc    <= '0;
          end else begin
            acc <= acc - 3'sd1;
          end
        end
        MV_BAD: acc <= '0;
      endcase
      if (mv == MV_BAD) begin
        err_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.step  = step_q;
  assign bus.dir   = dir_q;
  assign bus.err   = err_q;
  assign bus.phase = phase_q;

endmodule

// File: tb/tb_quadrature_step_filter.sv
// Bench for quadrature_step_filter: EDGES_PER_STEP 4 and 1 side by side.
// Vector table, hand sequences and random moves against a detent model.
module tb_quadrature_step_filter;

  localparam int FW  = 3;
  localparam int SS  = 2;
  localparam int LAT = SS + (1 << FW) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  quadrature_step_filter_if bus4();
  quadrature_step_filter_if bus1();

  quadrature_step_filter #(
    .SYNC_STAGES(SS), .FILTER_WIDTH(FW), .EDGES_PER_STEP(4)
  ) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  quadrature_step_filter #(
    .SYNC_STAGES(SS), .FILTER_WIDTH(FW), .EDGES_PER_STEP(1)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n4 = 0;
  int n1 = 0;
  int last4 = 0;
  int last1 = 0;
  logic p4 = 1'b0;
  logic p1 = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus4.step) begin
      chk("step4_back_to_back", int'(p4), 0);
      n4++;
      last4 = cyc;
    end
    if (bus1.step) begin
      chk("step1_back_to_back", int'(p1), 0);
      if (n1 > 0) chk("step1_gap_ok", int'((cyc - last1) >= (1 << FW)), 1);
      n1++;
      last1 = cyc;
    end
    p4 = bus4.step;
    p1 = bus1.step;
  end

  // Detent model: count signed edges along the CW cycle; a full
  // detent's worth in one direction emits a step.
  logic [1:0] mph = 2'b11;
  int   me[2] = '{0, 0};
  int   eps[2] = '{4, 1};
  logic mdir[2] = '{1'b0, 1'b0};
  logic merr = 1'b0;

  function automatic int pos(input logic [1:0] p);
    logic [1:0] cw[4];
    cw = '{2'b11, 2'b10, 2'b00, 2'b01};
    for (int i = 0; i < 4; i++) if (cw[i] == p) return i;
    return 0;
  endfunction

  task automatic model_move(
    input logic [1:0] nw, output int s4, output int s1
  );
    int d;
    int s;
    d = (pos(nw) - pos(mph) + 4) % 4;
    mph = nw;
    s4 = 0;
    s1 = 0;
    if (d == 2) merr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s = 0;
      if (d == 2) begin
        me[k] = 0;
      end else if (d == 1) begin
        me[k]++;
        if (me[k] == eps[k]) begin s = 1; mdir[k] = 1'b1; me[k] = 0; end
      end else if (d == 3) begin
        me[k]--;
        if (me[k] == -eps[k]) begin s = 1; mdir[k] = 1'b0; me[k] = 0; end
      end
      if (k == 0) s4 = s; else s1 = s;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pins(input logic [1:0] p);
    bus4.a = p[1]; bus4.b = p[0];
    bus1.a = p[1]; bus1.b = p[0];
  endtask

  task automatic set_clr(input logic v);
    bus4.err_clr = v;
    bus1.err_clr = v;
  endtask

  task automatic window(
    input logic [1:0] nw, input int hold,
    output int g4, output int g1, output int l4, output int l1,
    output int m4, output int m1
  );
    int b4, b1, c0;
    b4 = n4;
    b1 = n1;
    c0 = cyc;
    set_pins(nw);
    model_move(nw, m4, m1);
    tick(hold);
    g4 = n4 - b4;
    g1 = n1 - b1;
    l4 = last4 - c0;
    l1 = last1 - c0;
  endtask

  typedef struct {
    logic [1:0] pins;
    int         s4;
    logic       d4;
    int         s1;
    logic       d1;
    logic       err;
    logic [1:0] ph;
  } vec_t;

  vec_t tbl[17];
  int g4, g1, l4, l1, m4, m1, b4, b1;
  logic [1:0] nw;

  initial begin
    tbl[0]  = '{2'b10, 0, 1'b0, 1, 1'b1, 1'b0, 2'b10};
    tbl[1]  = '{2'b00, 0, 1'b0, 1, 1'b1, 1'b0, 2'b00};
    tbl[2]  = '{2'b01, 0, 1'b0, 1, 1'b1, 1'b0, 2'b01};
    tbl[3]  = '{2'b11, 1, 1'b1, 1, 1'b1, 1'b0, 2'b11};
    tbl[4]  = '{2'b01, 0, 1'b0, 1, 1'b0, 1'b0, 2'b01};
    tbl[5]  = '{2'b00, 0, 1'b0, 1, 1'b0, 1'b0, 2'b00};
    tbl[6]  = '{2'b10, 0, 1'b0, 1, 1'b0, 1'b0, 2'b10};
    tbl[7]  = '{2'b11, 1, 1'b0, 1, 1'b0, 1'b0, 2'b11};
    tbl[8]  = '{2'b10, 0, 1'b0, 1, 1'b1, 1'b0, 2'b10};
    tbl[9]  = '{2'b00, 0, 1'b0, 1, 1'b1, 1'b0, 2'b00};
    tbl[10] = '{2'b10, 0, 1'b0, 1, 1'b0, 1'b0, 2'b10};
    tbl[11] = '{2'b11, 0, 1'b0, 1, 1'b0, 1'b0, 2'b11};
    tbl[12] = '{2'b10, 0, 1'b0, 1, 1'b1, 1'b0, 2'b10};
    tbl[13] = '{2'b00, 0, 1'b0, 1, 1'b1, 1'b0, 2'b00};
    tbl[14] = '{2'b01, 0, 1'b0, 1, 1'b1, 1'b0, 2'b01};
    tbl[15] = '{2'b11, 1, 1'b1, 1, 1'b1, 1'b0, 2'b11};
    tbl[16] = '{2'b00, 0, 1'b0, 0, 1'b0, 1'b1, 2'b00};

    set_pins(2'b11);
    set_clr(1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_step", int'(bus4.step), 0);
    chk("rst_dir", int'(bus4.dir), 0);
    chk("rst_err", int'(bus4.err), 0);
    chk("rst_phase", int'(bus4.phase), 3);
    chk("rst_phase1", int'(bus1.phase), 3);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick(5);

    for (int i = 0; i < 17; i++) begin
      window(tbl[i].pins, 20, g4, g1, l4, l1, m4, m1);
      chk($sformatf("t%0d_steps4", i), g4, tbl[i].s4);
      chk($sformatf("t%0d_steps1", i), g1, tbl[i].s1);
      chk($sformatf("t%0d_phase4", i), int'(bus4.phase), int'(tbl[i].ph));
      chk($sformatf("t%0d_phase1", i), int'(bus1.phase), int'(tbl[i].ph));
      chk($sformatf("t%0d_err4", i), int'(bus4.err), int'(tbl[i].err));
      chk($sformatf("t%0d_err1", i), int'(bus1.err), int'(tbl[i].err));
      if (tbl[i].s4 > 0) begin
        chk($sformatf("t%0d_dir4", i), int'(bus4.dir), int'(tbl[i].d4));
        chk($sformatf("t%0d_lat4", i), l4, LAT);
      end
      if (tbl[i].s1 > 0) begin
        chk($sformatf("t%0d_dir1", i), int'(bus1.dir), int'(tbl[i].d1));
        chk($sformatf("t%0d_lat1", i), l1, LAT);
      end
    end

    // Second illegal jump lands on the same edge as err_clr.
    b4 = n4;
    b1 = n1;
    set_pins(2'b11);
    model_move(2'b11, m4, m1);
    tick(LAT - 1);
    set_clr(1'b1);
    tick(1);
    set_clr(1'b0);
    tick(5);
    chk("clr_vs_set_err4", int'(bus4.err), 1);
    chk("clr_vs_set_err1", int'(bus1.err), 1);
    chk("clr_vs_set_phase", int'(bus4.phase), 3);
    chk("clr_vs_set_steps", (n4 - b4) + (n1 - b1), 0);

    set_clr(1'b1);
    tick(1);
    set_clr(1'b0);
    merr = 1'b0;
    tick(1);
    chk("lone_clr_err4", int'(bus4.err), 0);
    chk("lone_clr_err1", int'(bus1.err), 0);

    // Asynchronous reset mid-clock while err is set and phase is 00.
    window(2'b00, 20, g4, g1, l4, l1, m4, m1);
    chk("pre_rst_err", int'(bus4.err), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_err4", int'(bus4.err), 0);
    chk("async_rst_err1", int'(bus1.err), 0);
    chk("async_rst_step", int'(bus4.step), 0);
    chk("async_rst_phase4", int'(bus4.phase), 3);
    chk("async_rst_phase1", int'(bus1.phase), 3);
    set_pins(2'b11);
    mph = 2'b11;
    me[0] = 0;
    me[1] = 0;
    merr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    b4 = n4;
    b1 = n1;
    tick(100);
    chk("post_rst_steps", (n4 - b4) + (n1 - b1), 0);
    chk("post_rst_phase", int'(bus4.phase), 3);

    // Bounces shorter than the filter window leave no trace.
    b4 = n4;
    b1 = n1;
    for (int i = 0; i < 10; i++) begin
      set_pins(2'b01);
      tick(5);
      set_pins(2'b11);
      tick(5);
    end
    tick(20);
    chk("bounce_phase4", int'(bus4.phase), 3);
    chk("bounce_phase1", int'(bus1.phase), 3);
    chk("bounce_steps", (n4 - b4) + (n1 - b1), 0);
    chk("bounce_err", int'(bus4.err), 0);

    for (int i = 0; i < 60; i++) begin
      nw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        set_pins(mph ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01));
        tick($urandom_range(1, 5));
        set_pins(mph);
        tick($urandom_range(1, 4));
      end
      window(nw, 20 + $urandom_range(0, 6), g4, g1, l4, l1, m4, m1);
      chk($sformatf("r%0d_steps4", i), g4, m4);
      chk($sformatf("r%0d_steps1", i), g1, m1);
      chk($sformatf("r%0d_phase", i), int'(bus4.phase), int'(mph));
      chk($sformatf("r%0d_err", i), int'(bus4.err), int'(merr));
      if (m4 > 0) begin
        chk($sformatf("r%0d_dir4", i), int'(bus4.dir), int'(mdir[0]));
        chk($sformatf("r%0d_lat4", i), l4, LAT);
      end
      if (m1 > 0) begin
        chk($sformatf("r%0d_dir1", i), int'(bus1.dir), int'(mdir[1]));
        chk($sformatf("r%0d_lat1", i), l1, LAT);
      end
      if ($urandom_range(0, 3) == 0) begin
        set_clr(1'b1);
        tick(1);
        set_clr(1'b0);
        merr = 1'b0;
        tick(1);
        chk($sformatf("r%0d_clr", i), int'(bus1.err), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
